shift_rows_pipe: RTL and testbench
==================================

Name: shift_rows_pipe

Overview:
Parametrised, registered ShiftRows stage for the pipelined Rijndael datapath. It generalises ShiftRows to block sizes Nb = 4, 6 or 8 columns, selects forward or inverse ShiftRows per transaction, and carries data through STAGES registers under valid/ready backpressure. It sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the encryption and decryption round pipelines.

Parameters:
NB, 4, state columns (legal values 4, 6, 8); BLOCK_LENGTH = 32*NB.
STAGES, 1, register stages (legal range 1..4); this is the zero-stall latency.
OCC_W, 3, width of OCCUPANCY; must hold the value STAGES.

Ports:
CLK  input  1  clock; all registers are rising-edge.
RST_N  input  1  asynchronous active-low reset.
CLR  input  1  synchronous flush of all in-flight data.
IN_VALID  input  1  input beat valid.
IN_READY  output  1  stage 1 can accept a beat.
IN_INV  input  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with the beat.
IN  input  32*NB  state in.
OUT_VALID  output  1  final stage holds a beat.
OUT_READY  input  1  downstream accepts.
OUT  output  32*NB  shifted state out.
OCCUPANCY  output  OCC_W  number of valid stages.

Behaviour:
- Byte map: byte i occupies IN[BLOCK_LENGTH-1-8i -: 8], so byte 0 is the MSB byte. Byte i sits at row i%4, column i/4 (column-major).
- Row offsets C0..C3: 0,1,2,3 for NB = 4 and NB = 6; 0,1,3,4 for NB = 8.
- Forward: out(r,c) = in(r, (c+Cr) mod NB).
- Inverse: out(r,c) = in(r, (c-Cr) mod NB).
- The transform is combinational on IN ahead of stage 1. Later stages carry data unchanged. The mode is not stored past stage 1.
- Each stage k holds valid_k and data_k.
- Stage k loads when (!valid_k || adv_k). adv_STAGES = OUT_READY. adv_k = load_(k+1) for k < STAGES.
- IN_READY = load_1, which is combinationally dependent on OUT_READY. A bubble anywhere lets the stages upstream of it advance.
- Input is accepted on IN_VALID && IN_READY. On load, valid_k takes the upstream valid (IN_VALID for stage 1).
- OUT = data_STAGES; OUT_VALID = valid_STAGES.
- OUT and OUT_VALID must hold stable while OUT_VALID && !OUT_READY.
- Throughput is 1 beat per cycle when OUT_READY is held high. Latency is STAGES cycles from acceptance to OUT_VALID.
- OCCUPANCY is the registered count of valid_k bits. It updates +1, -1 or unchanged, including on simultaneous accept and drain.
- CLR clears all valid_k and OCCUPANCY to 0 on the next edge and has priority over any load. IN_READY stays as computed during CLR, but a beat accepted in the CLR cycle is discarded.
- Reset (RST_N low, any time, including mid-stream): all valid_k = 0, all data_k = 0, OCCUPANCY = 0. Therefore OUT_VALID = 0 and OUT = 0. IN_READY = 1 once reset is released.
- Data registers change only on load, never on stall.

Test Plan:
- Forward, NB=4, STAGES=1: IN = d42711aee0bf98f1b8b45de51e415230 with IN_INV=0 -> one cycle later OUT = d4bf5d30e0b452aeb84111f11e2798e5, OUT_VALID=1.
- Inverse, NB=4: IN = d4bf5d30e0b452aeb84111f11e2798e5 with IN_INV=1 -> OUT = d42711aee0bf98f1b8b45de51e415230. A 16-beat random stream alternating forward/inverse round-trips through a second instance back to the original data.
- NB=8: IN bytes 00..1f with IN_INV=0 -> OUT column 0 = 00 05 0e 13 and column 1 = 04 09 12 17. Inverse of that result returns 00..1f.
- Backpressure, STAGES=3, continuous input: hold OUT_READY=0 for 5 cycles.
  - OCCUPANCY rises to 3, then IN_READY=0.
  - OUT stays stable while stalled.
  - On release, beats emerge in order with no loss or duplication, 1 per cycle.
- Bubble collapse, STAGES=3: send one beat, stall output, send a second beat 2 cycles later -> both beats queue and OCCUPANCY=2. The pipeline then drains in order.
- CLR and reset mid-stream with OCCUPANCY=3:
  - CLR -> next cycle OUT_VALID=0 and OCCUPANCY=0; the beat offered in the CLR cycle never appears at OUT.
  - Asynchronous RST_N pulse between clock edges -> outputs are 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// Registered Rijndael ShiftRows stage for Nb = 4/6/8 with per-beat forward/inverse
// selection and a STAGES-deep elastic pipeline under valid/ready backpressure.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int OCC_W  = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CLR,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic                IN_INV,
    input  logic [32*NB-1:0]    IN,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [32*NB-1:0]    OUT,
    output logic [OCC_W-1:0]    OCCUPANCY
);

    localparam int BL = 32 * NB;

    // Rijndael row offsets: rows 2 and 3 skip one extra column for 256-bit blocks.
    function automatic int row_offset(input int r);
        int off;
        if ((NB == 32'sd8) && (r >= 32'sd2)) begin
            off = r + 32'sd1;
        end else begin
            off = r;
        end
        return off;
    endfunction

    // Column-major byte permutation; byte 0 is the most significant byte.
    function automatic logic [BL-1:0] shift_rows(input logic [BL-1:0] st, input logic inv);
        logic [BL-1:0] res;
        int            src;
        res = '0;
        for (int c = 32'sd0; c < NB; c++) begin
            for (int r = 32'sd0; r < 32'sd4; r++) begin
                if (inv) begin
                    src = (c - row_offset(r) + NB) % NB;
                end else begin
                    src = (c + row_offset(r)) % NB;
                end
                res[BL - 32'sd8 - 32'sd8 * (c * 32'sd4 + r) +: 8] =
                    st[BL - 32'sd8 - 32'sd8 * (src * 32'sd4 + r) +: 8];
            end
        end
        return res;
    endfunction

    logic [STAGES-1:0] valid_r;
    logic [BL-1:0]     data_r [STAGES];
    logic [OCC_W-1:0]  occ_r;
    logic [STAGES-1:0] load_s;
    logic [BL-1:0]     shifted_s;
    logic              accept_s;
    logic              drain_s;

    // Ready ripples back from the output: a stage loads if it is empty or its successor loads.
    always_comb begin
        logic chain_v;
        chain_v = OUT_READY;
        load_s  = '0;
        for (int k = STAGES - 1; k >= 32'sd0; k--) begin
            load_s[k] = !valid_r[k] || chain_v;
            chain_v   = load_s[k];
        end
    end

    // Transform ahead of stage 1 plus occupancy bookkeeping strobes.
    always_comb begin
        shifted_s = shift_rows(IN, IN_INV);
        accept_s  = IN_VALID && load_s[0];
        drain_s   = valid_r[STAGES-1] && OUT_READY;
    end

    // Pipeline registers; data only moves on load, CLR drops every valid bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_r <= '0;
            for (int k = 32'sd0; k < STAGES; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            if (load_s[0]) begin
                data_r[0] <= shifted_s;
            end
            for (int k = 32'sd1; k < STAGES; k++) begin
                if (load_s[k]) begin
                    data_r[k] <= data_r[k-1];
                end
            end
            if (CLR) begin
                valid_r <= '0;
            end else begin
                if (load_s[0]) begin
                    valid_r[0] <= IN_VALID;
                end
                for (int k = 32'sd1; k < STAGES; k++) begin
                    if (load_s[k]) begin
                        valid_r[k] <= valid_r[k-1];
                    end
                end
            end
        end
    end

    // Occupancy tracks accepts minus drains, so interior bubble movement never changes it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            occ_r <= '0;
        end else if (CLR) begin
            occ_r <= '0;
        end else if (accept_s && !drain_s) begin
            occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
        end else if (drain_s && !accept_s) begin
            occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
        end else begin
            occ_r <= occ_r;
        end
    end

    assign IN_READY  = load_s[0];
    assign OUT_VALID = valid_r[STAGES-1];
    assign OUT       = data_r[STAGES-1];
    assign OCCUPANCY = occ_r;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: literal vectors, round trip, NB=8,
// and a queue-based model for a 3-stage pipe under random backpressure.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ShiftRows on a grid of bytes, result right-aligned in 256 bits.
    function automatic logic [255:0] ref_shift(input logic [255:0] x, input int nb, input bit inv);
        logic [7:0]   s [4][8];
        logic [255:0] y;
        int           off [4];
        int           sh;
        if (nb == 8) off = '{0, 1, 3, 4};
        else         off = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = x[nb*32 - 8 - 8*(4*c + r) +: 8];
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++) begin
                sh = inv ? (nb - off[r]) : off[r];
                y[nb*32 - 8 - 8*(4*c + r) +: 8] = s[r][(c + sh) % nb];
            end
        return y;
    endfunction

    // Instance a (NB=4, 1 stage) feeds instance b for the round trip.
    logic         a_valid, a_ready, a_inv, a_ov, b_ready, b_inv, b_ov;
    logic [127:0] a_in, a_out, b_out;
    logic [2:0]   a_occ, b_occ;

    shift_rows_pipe #(.NB(4), .STAGES(1), .OCC_W(3)) u_a (
        .CLK(clk), .RST_N(rst_n), .CLR(1'b0), .IN_VALID(a_valid), .IN_READY(a_ready),
        .IN_INV(a_inv), .IN(a_in), .OUT_VALID(a_ov), .OUT_READY(b_ready), .OUT(a_out),
        .OCCUPANCY(a_occ));

    shift_rows_pipe #(.NB(4), .STAGES(1), .OCC_W(3)) u_b (
        .CLK(clk), .RST_N(rst_n), .CLR(1'b0), .IN_VALID(a_ov), .IN_READY(b_ready),
        .IN_INV(b_inv), .IN(a_out), .OUT_VALID(b_ov), .OUT_READY(1'b1), .OUT(b_out),
        .OCCUPANCY(b_occ));

    logic         w_valid, w_ready, w_inv, w_ov;
    logic [255:0] w_in, w_out;
    logic [2:0]   w_occ;

    shift_rows_pipe #(.NB(8), .STAGES(1), .OCC_W(3)) u_w (
        .CLK(clk), .RST_N(rst_n), .CLR(1'b0), .IN_VALID(w_valid), .IN_READY(w_ready),
        .IN_INV(w_inv), .IN(w_in), .OUT_VALID(w_ov), .OUT_READY(1'b1), .OUT(w_out),
        .OCCUPANCY(w_occ));

    logic         p_valid, p_ready, p_inv, p_ov, p_oready, p_clr;
    logic [127:0] p_in, p_out;
    logic [2:0]   p_occ;

    shift_rows_pipe #(.NB(4), .STAGES(3), .OCC_W(3)) u_p (
        .CLK(clk), .RST_N(rst_n), .CLR(p_clr), .IN_VALID(p_valid), .IN_READY(p_ready),
        .IN_INV(p_inv), .IN(p_in), .OUT_VALID(p_ov), .OUT_READY(p_oready), .OUT(p_out),
        .OCCUPANCY(p_occ));

    // Model of u_p: FIFO of expected outputs with the edge count at which each was accepted.
    logic [127:0] q_data [$];
    int           q_acc  [$];
    int           cnt = 0;
    bit           chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [255:0] t;
        bit           mv, mr;
        if (!rst_n) begin
            q_data.delete();
            q_acc.delete();
        end else begin
            mv = (q_data.size() > 0) && (cnt - q_acc[0] >= 2);
            mr = (q_data.size() < 3) || p_oready;
            cnt++;
            if (mv && p_oready) begin
                void'(q_data.pop_front());
                void'(q_acc.pop_front());
            end
            if (p_valid && mr) begin
                t = ref_shift({128'd0, p_in}, 4, p_inv);
                q_data.push_back(t[127:0]);
                q_acc.push_back(cnt);
            end
            if (p_clr) begin
                q_data.delete();
                q_acc.delete();
            end
        end
    end

    logic [127:0] prev_out;
    bit           prev_stall = 1'b0;
    bit           prev_clr   = 1'b0;

    always @(negedge clk) begin
        bit ev;
        if (rst_n && chk_en) begin
            ev = (q_data.size() > 0) && (cnt - q_acc[0] >= 2);
            check("p_out_valid", 256'(p_ov), 256'(ev));
            if (ev) check("p_out_data", 256'(p_out), 256'(q_data[0]));
            check("p_occupancy", 256'(p_occ), 256'(q_data.size()));
            check("p_in_ready", 256'(p_ready), 256'((q_data.size() < 3) || p_oready));
            if (prev_stall && !prev_clr) check("p_stall_hold", 256'(p_out), 256'(prev_out));
            prev_stall = ev && !p_oready;
            prev_out   = p_out;
            prev_clr   = p_clr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] fwd_in, fwd_out;
    logic [255:0] seq32, tmp;
    logic [127:0] rt_q [$];

    initial begin
        fwd_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
        fwd_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        {a_valid, a_inv, b_inv, w_valid, w_inv, p_valid, p_inv, p_oready, p_clr} = '0;
        a_in = '0; w_in = '0; p_in = '0;
        rst_n = 1'b0;
        #3;
        check("rst_out_valid", 256'(p_ov), 256'd0);
        check("rst_out", 256'(p_out), 256'd0);
        check("rst_occupancy", 256'(p_occ), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 256'(p_ready), 256'd1);

        // Literal vectors pin both the model and the DUT.
        check("model_fwd", ref_shift({128'd0, fwd_in}, 4, 1'b0), 256'(fwd_out));
        check("model_inv", ref_shift({128'd0, fwd_out}, 4, 1'b1), 256'(fwd_in));
        step(); a_valid = 1'b1; a_inv = 1'b0; a_in = fwd_in;
        step(); a_valid = 1'b0;
        @(negedge clk);
        check("fwd_valid", 256'(a_ov), 256'd1);
        check("fwd_data", 256'(a_out), 256'(fwd_out));
        step(); a_valid = 1'b1; a_inv = 1'b1; a_in = fwd_out;
        step(); a_valid = 1'b0;
        @(negedge clk);
        check("inv_data", 256'(a_out), 256'(fwd_in));

        for (int i = 0; i < 32; i++) seq32[255 - 8*i -: 8] = 8'(i);
        tmp = ref_shift(seq32, 8, 1'b0);
        check("model_nb8_col0", 256'(tmp[255 -: 32]), 256'h00050e13);
        step(); w_valid = 1'b1; w_inv = 1'b0; w_in = seq32;
        step(); w_valid = 1'b0;
        @(negedge clk);
        check("nb8_col0", 256'(w_out[255 -: 32]), 256'h00050e13);
        check("nb8_col1", 256'(w_out[223 -: 32]), 256'h04091217);
        check("nb8_full", w_out, tmp);
        tmp = w_out;
        step(); w_valid = 1'b1; w_inv = 1'b1; w_in = tmp;
        step(); w_valid = 1'b0;
        @(negedge clk);
        check("nb8_inverse", w_out, seq32);

        // Round trip: b applies the opposite mode of the beat a just produced.
        for (int i = 0; i < 18; i++) begin
            step();
            b_inv = ~a_inv;
            if (i < 16) begin
                a_valid = 1'b1; a_inv = 1'(i % 2); a_in = rnd128();
                rt_q.push_back(a_in);
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clk);
            if (i >= 2) begin
                check("rt_valid", 256'(b_ov), 256'd1);
                if (rt_q.size() > 0) check("rt_data", 256'(b_out), 256'(rt_q.pop_front()));
            end
        end
        check("rt_all_returned", 256'(rt_q.size()), 256'd0);

        chk_en = 1'b1;
        // Backpressure: stall output for 5 cycles under continuous input.
        step(); p_oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p_valid = 1'b1; p_inv = 1'($urandom % 2); p_in = rnd128();
            step();
        end
        @(negedge clk);
        check("bp_full_occ", 256'(p_occ), 256'd3);
        check("bp_in_ready", 256'(p_ready), 256'd0);
        step(); p_oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p_in = rnd128();
            @(negedge clk);
            check("bp_stream", 256'(p_ov), 256'd1);
            step();
        end
        p_valid = 1'b0;
        repeat (5) step();

        // Bubble collapse: two beats separated by idle cycles queue behind a stall.
        p_oready = 1'b0;
        p_valid = 1'b1; p_in = rnd128();
        step(); p_valid = 1'b0;
        step(); step();
        p_valid = 1'b1; p_in = rnd128();
        step(); p_valid = 1'b0;
        @(negedge clk);
        check("bubble_occ", 256'(p_occ), 256'd2);
        step(); p_oready = 1'b1;
        repeat (5) step();

        // CLR with a full pipe; the beat offered alongside CLR must be discarded.
        p_oready = 1'b0; p_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p_in = rnd128();
            step();
        end
        p_clr = 1'b1; p_oready = 1'b1; p_in = rnd128();
        step(); p_clr = 1'b0; p_valid = 1'b0;
        @(negedge clk);
        check("clr_out_valid", 256'(p_ov), 256'd0);
        check("clr_occ", 256'(p_occ), 256'd0);
        repeat (5) step();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            p_valid  = ($urandom % 4) != 0;
            p_oready = ($urandom % 3) != 0;
            p_inv    = 1'($urandom % 2);
            p_in     = rnd128();
            p_clr    = ($urandom % 40) == 0;
            step();
        end
        p_valid = 1'b0; p_clr = 1'b0; p_oready = 1'b1;
        repeat (5) step();

        // Asynchronous reset pulse between edges with a full pipe.
        p_oready = 1'b0; p_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p_in = rnd128();
            step();
        end
        p_valid = 1'b0;
        chk_en = 1'b0;
        @(negedge clk);
        check("pre_rst_occ", 256'(p_occ), 256'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 256'(p_ov), 256'd0);
        check("arst_out", 256'(p_out), 256'd0);
        check("arst_occ", 256'(p_occ), 256'd0);
        #1 rst_n = 1'b1;
        #1;
        check("arst_in_ready", 256'(p_ready), 256'd1);
        step();
        chk_en = 1'b1;
        p_oready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
